uart_mmio_ctrl: RTL and testbench
=================================

Name: uart_mmio_ctrl

Overview:
Memory-mapped UART controller between the CPU load/store path and the UART transmitter/receiver. It buffers outgoing bytes in a TX FIFO and incoming bytes in an RX FIFO, and drives the valid/ready handshake on each side. It replaces direct CPU-to-UART coupling, so stores never wait on a busy transmitter and received bytes are not lost between polls. It decodes the UART window at BASE and exposes status, data and count/error registers.

Parameters:
DEPTH_LOG2, 3, log2 of entries per FIFO (8 entries each)
BASE, 32'h80000000, base address of the UART register window

Ports:
clk  in  1  system clock, all state on rising edge
rst_n  in  1  asynchronous active-low reset
A  in  32  CPU byte address (ALU_out)
WD  in  32  CPU store data (RT); only [7:0] used
LdStCtrl  in  3  000 LB, 001 LH, 010 LW, 011 LBU, 100 LHU, 101 SB, 110 SH, 111 SW
MemEn  in  1  CPU memory access this cycle
Out  out  32  load data for a UART-window address, else 0
DataIn  out  8  byte to UART transmitter (TX FIFO head)
DataInValid  out  1  TX FIFO non-empty
DataInReady  in  1  transmitter accepts byte this cycle
DataOut  in  8  byte from UART receiver
DataOutValid  in  1  one-cycle pulse: DataOut holds a new received byte

Behaviour:
- Register map, word-aligned, any other address in the window decodes to nothing (Out=0):
  BASE+0x0 RO: Out = {31'b0, ~tx_full}
  BASE+0x4 RO: Out = {31'b0, ~rx_empty}
  BASE+0x8 WO: store pushes WD[7:0] to TX FIFO; a load returns 0
  BASE+0xC RO: Out = {24'b0, rx_head} (0 if empty); a load pops
  BASE+0x10 RO: Out = {14'b0, rx_overrun, tx_overflow, rx_count[7:0], tx_count[7:0]}; counts zero-extended; a load clears both sticky bits
- Store = MemEn & LdStCtrl in {101,110,111}. Load = MemEn & LdStCtrl in {000..100}. Byte/half/word width is ignored.
- Out is combinational from A and registered state. All pushes, pops and flag updates take effect at the rising edge ending the access cycle.
- TX path:
  - DataIn = TX head; DataInValid = ~tx_empty, decoded from registered state only.
  - Pop when DataInValid & DataInReady.
  - A byte stored at edge N asserts DataInValid in cycle N+1, so the minimum store-to-UART latency is 1 cycle.
  - A store to full with a same-cycle pop is accepted; count unchanged.
  - A store to full with no pop is dropped, sets tx_overflow, and leaves FIFO contents unchanged.
- RX path:
  - When DataOutValid is high, DataOut is pushed.
  - If the FIFO is full and no pop occurs that cycle, the byte is dropped and rx_overrun is set.
  - Full with a same-cycle CPU pop: the byte is accepted and the count is unchanged.
  - A load of BASE+0xC when empty returns 0, does not pop and does not underflow.
- Pointers: DEPTH_LOG2-bit read/write pointers wrap modulo 2^DEPTH_LOG2. Counts are (DEPTH_LOG2+1) bits, range 0..2^DEPTH_LOG2.
- Sticky flags: a set event and a status-read clear in the same cycle leave the flag set (set wins).
- Reset (async assert, sync-safe release): pointers, counts and flags go to 0; DataInValid=0, DataIn=0, Out=0 for any non-status address.
  - Reset mid-transfer discards all buffered bytes.
  - No DataInValid glitch is allowed on assertion.

Test Plan:
1. Reset, then read BASE+0x0, 0x4, 0x10 -> 1, 0, 0; DataInValid=0.
2. SB 0x41 to BASE+0x8 with DataInReady=0 -> DataInValid=1 the next cycle, DataIn=0x41, tx_count=1. Raise DataInReady for 1 cycle -> DataInValid=0, tx_count=0.
3. 9 SW stores to BASE+0x8 (0x00..0x08) with DataInReady=0 -> BASE+0x0 reads 0 after the 8th store; the 9th sets bit 16 of BASE+0x10. Drain order is 0x00..0x07. A second read of BASE+0x10 shows bit 16 clear.
4. Pulse DataOutValid with 0x5A, then 0xA5 -> BASE+0x4 reads 1. LBU BASE+0xC returns 0x5A, then 0xA5, then 0 with no pop; rx_count ends at 0.
5. Fill RX with 8 bytes. Pulse a 9th byte in the same cycle as a pop -> accepted, count stays 8, no overrun. Pulse a 10th with no pop -> bit 17 set.
6. Assert rst_n=0 mid-drain with tx_count=5 -> DataInValid drops immediately; after release all counts and flags read 0.

Source files
------------

// File: rtl/uart_mmio_ctrl.sv
// rtl/uart_mmio_ctrl.sv - memory-mapped UART controller with TX/RX byte FIFOs
module uart_mmio_ctrl #(
  parameter int          DEPTH_LOG2 = 3,
  parameter logic [31:0] BASE       = 32'h8000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] A,
  input  logic [31:0] WD,
  input  logic [2:0]  LdStCtrl,
  input  logic        MemEn,
  output logic [31:0] Out,
  output logic [7:0]  DataIn,
  output logic        DataInValid,
  input  logic        DataInReady,
  input  logic [7:0]  DataOut,
  input  logic        DataOutValid
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam int CW    = DEPTH_LOG2 + 1;

  typedef logic [DEPTH_LOG2-1:0] ptr_t;
  typedef logic [CW-1:0]         cnt_t;

  localparam cnt_t FULL_CNT = cnt_t'(DEPTH);
  localparam cnt_t CNT_ONE  = cnt_t'(1);
  localparam ptr_t PTR_ONE  = ptr_t'(1);

  localparam logic [31:0] A_TXST = BASE;
  localparam logic [31:0] A_RXST = BASE + 32'h4;
  localparam logic [31:0] A_TXD  = BASE + 32'h8;
  localparam logic [31:0] A_RXD  = BASE + 32'hC;
  localparam logic [31:0] A_CNT  = BASE + 32'h10;

  logic [7:0] tx_mem [DEPTH];
  logic [7:0] rx_mem [DEPTH];
  ptr_t       tx_rd, tx_wr, rx_rd, rx_wr;
  cnt_t       tx_count, rx_count;
  logic       tx_overflow, rx_overrun;

  logic is_store, is_load;
  logic tx_full, tx_empty, rx_full, rx_empty;
  logic tx_req, tx_push, tx_pop, tx_ovf_set;
  logic rx_push, rx_pop, rx_ovr_set, flag_clr;
  logic [7:0] rx_head;
  logic unused_wd;

  assign unused_wd = ^WD[31:8];

  assign is_store = MemEn & LdStCtrl[2] & (LdStCtrl[1:0] != 2'b00);
  assign is_load  = MemEn & ~is_store;

  assign tx_full  = (tx_count == FULL_CNT);
  assign tx_empty = (tx_count == '0);
  assign rx_full  = (rx_count == FULL_CNT);
  assign rx_empty = (rx_count == '0);

  // A full FIFO still takes a new byte when its head leaves in the same cycle.
  assign tx_req     = is_store & (A == A_TXD);
  assign tx_pop     = ~tx_empty & DataInReady;
  assign tx_push    = tx_req & (~tx_full | tx_pop);
  assign tx_ovf_set = tx_req & tx_full & ~tx_pop;

  assign rx_pop     = is_load & (A == A_RXD) & ~rx_empty;
  assign rx_push    = DataOutValid & (~rx_full | rx_pop);
  assign rx_ovr_set = DataOutValid & rx_full & ~rx_pop;
  assign flag_clr   = is_load & (A == A_CNT);

  assign DataInValid = ~tx_empty;
  assign DataIn      = tx_empty ? 8'h00 : tx_mem[tx_rd];
  assign rx_head     = rx_empty ? 8'h00 : rx_mem[rx_rd];

  always_comb begin
    Out = 32'h0;
    if (A == A_TXST)      Out = {31'b0, ~tx_full};
    else if (A == A_RXST) Out = {31'b0, ~rx_empty};
    else if (A == A_RXD)  Out = {24'b0, rx_head};
    else if (A == A_CNT)  Out = {14'b0, rx_overrun, tx_overflow, 8'(rx_count), 8'(tx_count)};
  end

  always_ff @(posedge clk) begin
    if (tx_push) tx_mem[tx_wr] <= WD[7:0];
    if (rx_push) rx_mem[rx_wr] <= DataOut;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_rd       <= '0;
      tx_wr       <= '0;
      rx_rd       <= '0;
      rx_wr       <= '0;
      tx_count    <= '0;
      rx_count    <= '0;
      tx_overflow <= 1'b0;
      rx_overrun  <= 1'b0;
    end else begin
      if (tx_push) tx_wr <= tx_wr + PTR_ONE;
      if (tx_pop)  tx_rd <= tx_rd + PTR_ONE;
      if (rx_push) rx_wr <= rx_wr + PTR_ONE;
      if (rx_pop)  rx_rd <= rx_rd + PTR_ONE;
      tx_count <= tx_count + (tx_push ? CNT_ONE : '0) - (tx_pop ? CNT_ONE : '0);
      rx_count <= rx_count + (rx_push ? CNT_ONE : '0) - (rx_pop ? CNT_ONE : '0);
      // A set event in the same cycle as a status read keeps the flag set.
      if (tx_ovf_set)    tx_overflow <= 1'b1;
      else if (flag_clr) tx_overflow <= 1'b0;
      if (rx_ovr_set)    rx_overrun  <= 1'b1;
      else if (flag_clr) rx_overrun  <= 1'b0;
    end
  end

endmodule

// File: tb/tb_uart_mmio_ctrl.sv
// tb/tb_uart_mmio_ctrl.sv - vector table plus TX/RX byte scoreboards for uart_mmio_ctrl
module tb_uart_mmio_ctrl;

  localparam logic [31:0] B  = 32'h8000_0000;
  localparam logic [31:0] ST = B;
  localparam logic [31:0] RS = B + 32'h4;
  localparam logic [31:0] TD = B + 32'h8;
  localparam logic [31:0] RD = B + 32'hC;
  localparam logic [31:0] CS = B + 32'h10;
  localparam logic [2:0] LB = 3'b000, LW = 3'b010, LBU = 3'b011, SB = 3'b101, SW = 3'b111;

  logic        clk, rst_n;
  logic [31:0] A, WD, Out;
  logic [2:0]  LdStCtrl;
  logic        MemEn, DataInValid, DataInReady, DataOutValid;
  logic [7:0]  DataIn, DataOut;

  int checks = 0;
  int errors = 0;

  logic [7:0] txq[$];
  logic [7:0] rxq[$];

  typedef struct {
    logic        en;
    logic [2:0]  ctl;
    logic [31:0] a;
    logic [7:0]  wd;
    logic        rdy;
    logic        rxv;
    logic [7:0]  rxd;
    logic [2:0]  chk;
    logic [31:0] eo;
    logic        ev;
    logic [7:0]  ed;
  } vec_t;

  vec_t vecs[$];

  uart_mmio_ctrl #(.DEPTH_LOG2(3), .BASE(B)) dut (
    .clk(clk), .rst_n(rst_n), .A(A), .WD(WD), .LdStCtrl(LdStCtrl), .MemEn(MemEn),
    .Out(Out), .DataIn(DataIn), .DataInValid(DataInValid), .DataInReady(DataInReady),
    .DataOut(DataOut), .DataOutValid(DataOutValid)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n && DataInValid && DataInReady) begin
      if (txq.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL tx_drain: got %h expected no byte", DataIn);
      end else begin
        check("tx_drain", {24'b0, DataIn}, {24'b0, txq.pop_front()});
      end
    end
  end

  function automatic vec_t mk(logic en, logic [2:0] ctl, logic [31:0] a, logic [7:0] wd,
                              logic rdy, logic rxv, logic [7:0] rxd, logic [2:0] chk,
                              logic [31:0] eo, logic ev, logic [7:0] ed);
    vec_t v;
    v.en = en; v.ctl = ctl; v.a = a; v.wd = wd; v.rdy = rdy; v.rxv = rxv; v.rxd = rxd;
    v.chk = chk; v.eo = eo; v.ev = ev; v.ed = ed;
    return v;
  endfunction

  function automatic vec_t ldc(logic [31:0] a, logic [31:0] eo);
    return mk(1'b1, LW, a, 8'h00, 1'b0, 1'b0, 8'h00, 3'b001, eo, 1'b0, 8'h00);
  endfunction

  function automatic vec_t ldp();
    return mk(1'b1, LBU, RD, 8'h00, 1'b0, 1'b0, 8'h00, 3'b000, 32'h0, 1'b0, 8'h00);
  endfunction

  function automatic vec_t st(logic [7:0] d, logic rdy);
    return mk(1'b1, SW, TD, d, rdy, 1'b0, 8'h00, 3'b000, 32'h0, 1'b0, 8'h00);
  endfunction

  function automatic vec_t idle(logic rdy, logic rxv, logic [7:0] rxd, logic [2:0] chk,
                                logic ev, logic [7:0] ed);
    return mk(1'b0, LW, 32'h0, 8'h00, rdy, rxv, rxd, chk, 32'h0, ev, ed);
  endfunction

  // Drive one cycle; queues model the FIFO contents independently of the DUT.
  task automatic apply(vec_t v, int idx);
    bit is_st, is_ld, tx_acc, rx_pop, rx_acc;
    int txn, rxn;
    logic [7:0] exp_rx;
    MemEn = v.en; LdStCtrl = v.ctl; A = v.a; WD = {24'hABCDEF, v.wd};
    DataInReady = v.rdy; DataOutValid = v.rxv; DataOut = v.rxd;
    is_st = v.en && (v.ctl inside {SB, 3'b110, SW});
    is_ld = v.en && !is_st;
    txn = txq.size();
    rxn = rxq.size();
    tx_acc = is_st && (v.a == TD) && (txn < 8 || (v.rdy && txn > 0));
    if (tx_acc) txq.push_back(v.wd);
    rx_pop = is_ld && (v.a == RD) && rxn > 0;
    rx_acc = v.rxv && (rxn < 8 || rx_pop);
    #3;
    if (v.chk[0]) check($sformatf("vec%0d out", idx), Out, v.eo);
    if (v.chk[1]) check($sformatf("vec%0d valid", idx), {31'b0, DataInValid}, {31'b0, v.ev});
    if (v.chk[2]) check($sformatf("vec%0d datain", idx), {24'b0, DataIn}, {24'b0, v.ed});
    if (is_ld && v.a == RD) begin
      exp_rx = rx_pop ? rxq.pop_front() : 8'h00;
      check($sformatf("vec%0d rxdata", idx), Out, {24'b0, exp_rx});
    end
    if (rx_acc) rxq.push_back(v.rxd);
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0; MemEn = 1'b0; LdStCtrl = LW; A = 32'h0; WD = 32'h0;
    DataInReady = 1'b0; DataOutValid = 1'b0; DataOut = 8'h00;
    repeat (2) @(posedge clk);
    #1;
    check("reset_valid", {31'b0, DataInValid}, 32'h0);
    rst_n = 1'b1;

    // reset state and decode
    vecs.push_back(ldc(ST, 32'h1));
    vecs.push_back(ldc(RS, 32'h0));
    vecs.push_back(ldc(CS, 32'h0));
    vecs.push_back(ldc(32'h0, 32'h0));
    vecs.push_back(ldc(B + 32'h14, 32'h0));
    vecs.push_back(ldc(B + 32'h1, 32'h0));
    vecs.push_back(ldc(TD, 32'h0));
    vecs.push_back(idle(1'b0, 1'b0, 8'h00, 3'b110, 1'b0, 8'h00));
    // single byte, one-cycle latency
    vecs.push_back(mk(1'b1, SB, TD, 8'h41, 1'b0, 1'b0, 8'h00, 3'b010, 32'h0, 1'b0, 8'h00));
    vecs.push_back(idle(1'b0, 1'b0, 8'h00, 3'b110, 1'b1, 8'h41));
    vecs.push_back(ldc(CS, 32'h1));
    vecs.push_back(idle(1'b1, 1'b0, 8'h00, 3'b010, 1'b1, 8'h00));
    vecs.push_back(mk(1'b1, LW, CS, 8'h00, 1'b0, 1'b0, 8'h00, 3'b011, 32'h0, 1'b0, 8'h00));
    // TX fill, overflow, full-with-pop
    for (int d = 0; d < 8; d++) vecs.push_back(st(8'(d), 1'b0));
    vecs.push_back(ldc(ST, 32'h0));
    vecs.push_back(ldc(CS, 32'h8));
    vecs.push_back(st(8'h08, 1'b0));
    vecs.push_back(ldc(CS, 32'h0001_0008));
    vecs.push_back(ldc(CS, 32'h8));
    vecs.push_back(st(8'h99, 1'b1));
    vecs.push_back(ldc(CS, 32'h8));
    for (int d = 0; d < 8; d++) vecs.push_back(idle(1'b1, 1'b0, 8'h00, 3'b000, 1'b0, 8'h00));
    vecs.push_back(idle(1'b0, 1'b0, 8'h00, 3'b110, 1'b0, 8'h00));
    vecs.push_back(ldc(ST, 32'h1));
    vecs.push_back(ldc(CS, 32'h0));
    // RX basic and empty read
    vecs.push_back(idle(1'b0, 1'b1, 8'h5A, 3'b000, 1'b0, 8'h00));
    vecs.push_back(idle(1'b0, 1'b1, 8'hA5, 3'b000, 1'b0, 8'h00));
    vecs.push_back(ldc(RS, 32'h1));
    vecs.push_back(ldc(CS, 32'h0200));
    for (int d = 0; d < 3; d++) vecs.push_back(ldp());
    vecs.push_back(ldc(CS, 32'h0));
    vecs.push_back(ldc(RS, 32'h0));
    // RX full, push-with-pop, overrun with same-cycle clear
    for (int d = 0; d < 8; d++) vecs.push_back(idle(1'b0, 1'b1, 8'(8'h10 + d), 3'b000, 1'b0, 8'h00));
    vecs.push_back(ldc(CS, 32'h0800));
    vecs.push_back(mk(1'b1, LBU, RD, 8'h00, 1'b0, 1'b1, 8'h18, 3'b000, 32'h0, 1'b0, 8'h00));
    vecs.push_back(ldc(CS, 32'h0800));
    vecs.push_back(mk(1'b1, LB, CS, 8'h00, 1'b0, 1'b1, 8'h19, 3'b001, 32'h0800, 1'b0, 8'h00));
    vecs.push_back(ldc(CS, 32'h0002_0800));
    vecs.push_back(ldc(CS, 32'h0800));
    for (int d = 0; d < 8; d++) vecs.push_back(ldp());
    vecs.push_back(ldc(CS, 32'h0));

    foreach (vecs[i]) apply(vecs[i], i);

    // reset mid-drain discards everything
    for (int d = 0; d < 6; d++) apply(st(8'(8'hC0 + d), 1'b0), 1000 + d);
    apply(idle(1'b1, 1'b0, 8'h00, 3'b000, 1'b0, 8'h00), 1006);
    apply(idle(1'b0, 1'b1, 8'h77, 3'b000, 1'b0, 8'h00), 1007);
    apply(ldc(CS, 32'h0105), 1008);
    MemEn = 1'b0; DataOutValid = 1'b0; DataInReady = 1'b1;
    #2;
    rst_n = 1'b0;
    #1;
    check("rst_valid_drop", {31'b0, DataInValid}, 32'h0);
    check("rst_datain", {24'b0, DataIn}, 32'h0);
    txq.delete();
    rxq.delete();
    @(posedge clk);
    @(posedge clk);
    #1;
    DataInReady = 1'b0;
    rst_n = 1'b1;
    apply(ldc(CS, 32'h0), 2000);
    apply(ldc(ST, 32'h1), 2001);
    apply(ldc(RS, 32'h0), 2002);
    apply(idle(1'b0, 1'b0, 8'h00, 3'b110, 1'b0, 8'h00), 2003);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
